// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: widths, butterfly modes, saturate and shift helpers.
// Latency: none (package only).
// Backpressure: n/a. RADIX2_ROUND_EN selects round-half-up shifts instead of floor shifts.
package fft_pkg;

  localparam int DW_DEF = 12;
  localparam int TW_DEF = 12;

  localparam logic MODE_DIF = 1'b0;
  localparam logic MODE_DIT = 1'b1;

  // Accumulator width for all intermediate arithmetic; comfortably holds
  // (DW+1)+TW+2 bits for the widths this butterfly is used at.
  localparam int ACC_W = 48;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic sat;
    acc_t val;
  } sat_t;

  // Clamp v to the signed dw-bit range and report whether clamping happened.
  function automatic sat_t saturate(input acc_t v, input int dw);
    acc_t hi;
    acc_t lo;
    sat_t r;
    hi    = (acc_t'(1) <<< (dw - 1)) - acc_t'(1);
    lo    = -hi - acc_t'(1);
    r.sat = 1'b1;
    if (v > hi) begin
      r.val = hi;
    end else if (v < lo) begin
      r.val = lo;
    end else begin
      r.val = v;
      r.sat = 1'b0;
    end
    return r;
  endfunction

  // Arithmetic right shift by n (n >= 1), at full accumulator width.
  function automatic acc_t round_shift(input acc_t v, input int n);
`ifdef RADIX2_ROUND_EN
    acc_t half;
    half = acc_t'(1) <<< (n - 1);
    return (v + half) >>> n;
`else
    return v >>> n;
`endif
  endfunction

endpackage

// File: rtl/radix2_bf_pipe_if.sv
// Butterfly stream bundle: input beat (mode, scale, a, b, w), output beat (up, lo), ovf control.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides; slave is the butterfly, master the surrounding stage.
interface radix2_bf_pipe_if
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) ();

  logic            in_valid;
  logic            in_ready;
  logic            in_mode;
  logic            in_scale;
  logic [2*DW-1:0] in_a;
  logic [2*DW-1:0] in_b;
  logic [2*TW-1:0] in_w;

  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_up;
  logic [2*DW-1:0] out_lo;

  logic            ovf;
  logic            ovf_clr;

  modport slave (
    input  in_valid, in_mode, in_scale, in_a, in_b, in_w, out_ready, ovf_clr,
    output in_ready, out_valid, out_up, out_lo, ovf
  );

  modport master (
    output in_valid, in_mode, in_scale, in_a, in_b, in_w, out_ready, ovf_clr,
    input  in_ready, out_valid, out_up, out_lo, ovf
  );

endinterface

// File: rtl/cmplx_mult_pipe.sv
// Registered four partial products of complex x times twiddle w.
// Latency: 1 cycle.
// Backpressure: products hold while en is low.
module cmplx_mult_pipe #(
  parameter int XW = 13,
  parameter int WW = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [XW-1:0]    x_re,
  input  logic signed [XW-1:0]    x_im,
  input  logic signed [WW-1:0]    w_re,
  input  logic signed [WW-1:0]    w_im,
  output logic signed [XW+WW-1:0] p_rr,
  output logic signed [XW+WW-1:0] p_ii,
  output logic signed [XW+WW-1:0] p_ri,
  output logic signed [XW+WW-1:0] p_ir
);

  localparam int PW = XW + WW;

  // Full-width products; combining and shifting happen in the next stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (en) begin
      p_rr <= PW'(x_re) * PW'(w_re);
      p_ii <= PW'(x_im) * PW'(w_im);
      p_ri <= PW'(x_re) * PW'(w_im);
      p_ir <= PW'(x_im) * PW'(w_re);
    end
  end

endmodule

// File: rtl/radix2_bf_pipe.sv
// Pipelined radix-2 DIF/DIT butterfly with optional /2 scaling, saturation and sticky ovf.
// Latency: 3 cycles from accepted input to out_valid; 1 beat/cycle when out_ready is high.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready. RADIX2_ROUND_EN enables rounding.
module radix2_bf_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  radix2_bf_pipe_if.slave bus
);

  localparam int XW = DW + 1;
  localparam int PW = XW + TW;

  logic stall;
  logic en;
  logic out_valid_q;
  logic [2*DW-1:0] out_up_q;
  logic [2*DW-1:0] out_lo_q;
  logic ovf_q;

  // A held output beat is the only thing that can stop the pipe.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_up    = out_up_q;
  assign bus.out_lo    = out_lo_q;
  assign bus.ovf       = ovf_q;

  // ---------------- stage 1: operands and DIF add/sub ----------------
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW-1:0] w_re, w_im;

  assign a_re = bus.in_a[2*DW-1:DW];
  assign a_im = bus.in_a[DW-1:0];
  assign b_re = bus.in_b[2*DW-1:DW];
  assign b_im = bus.in_b[DW-1:0];
  assign w_re = bus.in_w[2*TW-1:TW];
  assign w_im = bus.in_w[TW-1:0];

  logic signed [XW-1:0] sum_re, sum_im, x_re, x_im;

  // Sum feeds the DIF upper output; x is the multiplicand (a-b for DIF, b for DIT).
  always_comb begin
    sum_re = XW'(a_re) + XW'(b_re);
    sum_im = XW'(a_im) + XW'(b_im);
    if (bus.in_mode == MODE_DIF) begin
      x_re = XW'(a_re) - XW'(b_re);
      x_im = XW'(a_im) - XW'(b_im);
    end else begin
      x_re = XW'(b_re);
      x_im = XW'(b_im);
    end
  end

  logic                 v1, s1_mode, s1_scale;
  logic signed [DW-1:0] s1_a_re, s1_a_im;
  logic signed [XW-1:0] s1_s_re, s1_s_im, s1_x_re, s1_x_im;
  logic signed [TW-1:0] s1_w_re, s1_w_im;

  // Stage 1 register: accepts a beat whenever the pipe is moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_mode  <= MODE_DIF;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_s_re  <= '0;
      s1_s_im  <= '0;
      s1_x_re  <= '0;
      s1_x_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else if (en) begin
      v1       <= bus.in_valid;
      s1_mode  <= bus.in_mode;
      s1_scale <= bus.in_scale;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_s_re  <= sum_re;
      s1_s_im  <= sum_im;
      s1_x_re  <= x_re;
      s1_x_im  <= x_im;
      s1_w_re  <= w_re;
      s1_w_im  <= w_im;
    end
  end

  // ---------------- stage 2: partial products ----------------
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  cmplx_mult_pipe #(
    .XW (XW),
    .WW (TW)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .x_re  (s1_x_re),
    .x_im  (s1_x_im),
    .w_re  (s1_w_re),
    .w_im  (s1_w_im),
    .p_rr  (p_rr),
    .p_ii  (p_ii),
    .p_ri  (p_ri),
    .p_ir  (p_ir)
  );

  logic                 v2, s2_mode, s2_scale;
  logic signed [DW-1:0] s2_a_re, s2_a_im;
  logic signed [XW-1:0] s2_s_re, s2_s_im;

  // Sideband travelling alongside the products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      s2_mode  <= MODE_DIF;
      s2_scale <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_s_re  <= '0;
      s2_s_im  <= '0;
    end else if (en) begin
      v2       <= v1;
      s2_mode  <= s1_mode;
      s2_scale <= s1_scale;
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
      s2_s_re  <= s1_s_re;
      s2_s_im  <= s1_s_im;
    end
  end

  // ---------------- stage 3: combine, scale, saturate ----------------
  acc_t prod_re, prod_im, t_re, t_im;
  acc_t pre [4];
  sat_t res [4];
  logic sat_any;

  // Component order in pre/res: up.re, up.im, lo.re, lo.im.
  always_comb begin
    prod_re = acc_t'(p_rr) - acc_t'(p_ii);
    prod_im = acc_t'(p_ri) + acc_t'(p_ir);
    t_re    = round_shift(prod_re, TW - 1);
    t_im    = round_shift(prod_im, TW - 1);
    if (s2_mode == MODE_DIF) begin
      pre[0] = acc_t'(s2_s_re);
      pre[1] = acc_t'(s2_s_im);
      pre[2] = t_re;
      pre[3] = t_im;
    end else begin
      pre[0] = acc_t'(s2_a_re) + t_re;
      pre[1] = acc_t'(s2_a_im) + t_im;
      pre[2] = acc_t'(s2_a_re) - t_re;
      pre[3] = acc_t'(s2_a_im) - t_im;
    end
    sat_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s2_scale) begin
        pre[k] = round_shift(pre[k], 1);
      end
      res[k]  = saturate(pre[k], DW);
      sat_any = sat_any | res[k].sat;
    end
  end

  // Upper bits of the clamped values are pure sign extension.
  logic unused_sat_hi;
  assign unused_sat_hi = ^{res[0].val[ACC_W-1:DW], res[1].val[ACC_W-1:DW],
                           res[2].val[ACC_W-1:DW], res[3].val[ACC_W-1:DW]};

  // Output register: only valid beats overwrite the data, so bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_up_q    <= '0;
      out_lo_q    <= '0;
    end else if (en) begin
      out_valid_q <= v2;
      if (v2) begin
        out_up_q <= {res[0].val[DW-1:0], res[1].val[DW-1:0]};
        out_lo_q <= {res[2].val[DW-1:0], res[3].val[DW-1:0]};
      end
    end
  end

  // Sticky overflow: a saturating beat entering the output register beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en && v2 && sat_any) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_radix2_bf_pipe.sv
// Directed self-checking bench for radix2_bf_pipe (DW = TW = 12).
// Latency: checks the 3-cycle input-to-output latency and stall/hold behaviour.
// Backpressure: drives out_ready low for a 5-cycle stall during a 6-beat stream.
module tb_radix2_bf_pipe;
  import fft_pkg::*;

  localparam int DW = 12;
  localparam int TW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  radix2_bf_pipe_if #(.DW(DW), .TW(TW)) bus ();

  radix2_bf_pipe #(.DW(DW), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stream vectors: w = -1 (0x800) or -j, results worked out by hand.
  logic bb_mode [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int bb_ar [6] = '{10, 10, -100, 0, 1000, 5};
  int bb_ai [6] = '{20, 20, 300, 0, -1000, 6};
  int bb_br [6] = '{1, 1, 50, 7, 1000, 7};
  int bb_bi [6] = '{2, 2, -25, -9, -1000, 8};
  int bb_wr [6] = '{-2048, -2048, -2048, 0, -2048, -2048};
  int bb_wi [6] = '{0, 0, 0, -2048, 0, 0};
  int ex_ur [6] = '{11, 9, -50, -9, 2000, 12};
  int ex_ui [6] = '{22, 18, 275, -7, -2000, 14};
  int ex_lr [6] = '{-9, 11, 150, 9, 0, 2};
  int ex_li [6] = '{-18, 22, -325, 7, 0, 2};

  function automatic logic [2*DW-1:0] pk(input int re, input int im);
    logic [DW-1:0] r, i;
    r = re[DW-1:0];
    i = im[DW-1:0];
    return {r, i};
  endfunction

  function automatic logic [2*TW-1:0] pkw(input int re, input int im);
    logic [TW-1:0] r, i;
    r = re[TW-1:0];
    i = im[TW-1:0];
    return {r, i};
  endfunction

  task automatic set_beat(input int k);
    bus.in_mode  = bb_mode[k];
    bus.in_scale = 1'b0;
    bus.in_a     = pk(bb_ar[k], bb_ai[k]);
    bus.in_b     = pk(bb_br[k], bb_bi[k]);
    bus.in_w     = pkw(bb_wr[k], bb_wi[k]);
  endtask

  // Present one beat, then count negedges until out_valid (bounded).
  task automatic send_one(input logic mode, input logic scale, input logic [2*DW-1:0] a,
                          input logic [2*DW-1:0] b, input logic [2*TW-1:0] w, output int lat);
    @(negedge clk);
    bus.in_mode  = mode;
    bus.in_scale = scale;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_w     = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_scale  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_w      = '0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_up !== '0) begin errors++; $display("FAIL reset_out_up: got %h want 0", bus.out_up); end
    checks++;
    if (bus.out_lo !== '0) begin errors++; $display("FAIL reset_out_lo: got %h want 0", bus.out_lo); end
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_dif();
    int lat;
    send_one(MODE_DIF, 1'b0, pk(100, 50), pk(20, 10), pkw(-2048, 0), lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL dif_latency: got %0d want 3", lat); end
    checks++;
    if (bus.out_up !== pk(120, 60)) begin errors++; $display("FAIL dif_up: got %h want %h", bus.out_up, pk(120, 60)); end
    checks++;
    if (bus.out_lo !== pk(-80, -40)) begin errors++; $display("FAIL dif_lo: got %h want %h", bus.out_lo, pk(-80, -40)); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL dif_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_dit();
    int lat;
    send_one(MODE_DIT, 1'b0, pk(100, 0), pk(30, 40), pkw(0, -2048), lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL dit_latency: got %0d want 3", lat); end
    checks++;
    if (bus.out_up !== pk(140, -30)) begin errors++; $display("FAIL dit_up: got %h want %h", bus.out_up, pk(140, -30)); end
    checks++;
    if (bus.out_lo !== pk(60, 30)) begin errors++; $display("FAIL dit_lo: got %h want %h", bus.out_lo, pk(60, 30)); end
  endtask

  task automatic test_scale();
    int lat;
    int up_re, lo_re;
`ifdef RADIX2_ROUND_EN
    up_re = 51;
    lo_re = -50;
`else
    up_re = 50;
    lo_re = -51;
`endif
    send_one(MODE_DIF, 1'b1, pk(101, 0), pk(0, 0), pkw(-2048, 0), lat);
    checks++;
    if (bus.out_up !== pk(up_re, 0)) begin errors++; $display("FAIL scale_up: got %h want %h", bus.out_up, pk(up_re, 0)); end
    checks++;
    if (bus.out_lo !== pk(lo_re, 0)) begin errors++; $display("FAIL scale_lo: got %h want %h", bus.out_lo, pk(lo_re, 0)); end
  endtask

  task automatic test_saturation();
    int lat;
    send_one(MODE_DIF, 1'b0, pk(2047, 0), pk(2047, 0), pkw(-2048, 0), lat);
    checks++;
    if (bus.out_up !== pk(2047, 0)) begin errors++; $display("FAIL sat_pos_up: got %h want %h", bus.out_up, pk(2047, 0)); end
    checks++;
    if (bus.out_lo !== pk(0, 0)) begin errors++; $display("FAIL sat_pos_lo: got %h want 0", bus.out_lo); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set: got %b want 1", bus.ovf); end
    send_one(MODE_DIF, 1'b0, pk(-2048, -2048), pk(-2048, -2048), pkw(-2048, 0), lat);
    checks++;
    if (bus.out_up !== pk(-2048, -2048)) begin errors++; $display("FAIL sat_neg_up: got %h want %h", bus.out_up, pk(-2048, -2048)); end
    send_one(MODE_DIF, 1'b0, pk(100, 50), pk(20, 10), pkw(-2048, 0), lat);
    checks++;
    if (bus.out_up !== pk(120, 60)) begin errors++; $display("FAIL sat_clean_up: got %h want %h", bus.out_up, pk(120, 60)); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b want 1", bus.ovf); end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr: got %b want 0", bus.ovf); end
    // Clear held high while a saturating beat lands: the set must win.
    bus.ovf_clr = 1'b1;
    send_one(MODE_DIF, 1'b0, pk(2047, 0), pk(2047, 0), pkw(-2048, 0), lat);
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b want 1", bus.ovf); end
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr2: got %b want 0", bus.ovf); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    bit stall_started = 1'b0;
    bit fire_in, fire_out;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && !stall_started) begin
        stall_started = 1'b1;
        stall_left    = 5;
      end
      bus.out_ready = (stall_left == 0);
      if (sent < 6) begin
        set_beat(sent);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #4;
      if (stall_left > 0) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b want 0", bus.in_ready); end
        checks++;
        if (bus.out_up !== pk(ex_ur[got], ex_ui[got])) begin
          errors++; $display("FAIL b2b_stall_up: got %h want %h", bus.out_up, pk(ex_ur[got], ex_ui[got]));
        end
        checks++;
        if (bus.out_lo !== pk(ex_lr[got], ex_li[got])) begin
          errors++; $display("FAIL b2b_stall_lo: got %h want %h", bus.out_lo, pk(ex_lr[got], ex_li[got]));
        end
        stall_left--;
      end
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        checks++;
        if (bus.out_up !== pk(ex_ur[got], ex_ui[got])) begin
          errors++; $display("FAIL b2b_up[%0d]: got %h want %h", got, bus.out_up, pk(ex_ur[got], ex_ui[got]));
        end
        checks++;
        if (bus.out_lo !== pk(ex_lr[got], ex_li[got])) begin
          errors++; $display("FAIL b2b_lo[%0d]: got %h want %h", got, bus.out_lo, pk(ex_lr[got], ex_li[got]));
        end
        got++;
      end
      if (fire_in) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got !== 6) begin errors++; $display("FAIL b2b_count_out: got %0d want 6", got); end
    checks++;
    if (sent !== 6) begin errors++; $display("FAIL b2b_count_in: got %0d want 6", sent); end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_beat: out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_in_flight();
    int lat;
    int stray = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_beat(k);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rif_in_flight: out_valid %b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rif_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_up !== '0) begin errors++; $display("FAIL rif_out_up: got %h want 0", bus.out_up); end
    checks++;
    if (bus.out_lo !== '0) begin errors++; $display("FAIL rif_out_lo: got %h want 0", bus.out_lo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL rif_stale_beats: got %0d want 0", stray); end
    send_one(MODE_DIF, 1'b0, pk(100, 50), pk(20, 10), pkw(-2048, 0), lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rif_latency: got %0d want 3", lat); end
    checks++;
    if (bus.out_up !== pk(120, 60)) begin errors++; $display("FAIL rif_up: got %h want %h", bus.out_up, pk(120, 60)); end
  endtask

  initial begin
    test_reset();
    test_dif();
    test_dit();
    test_scale();
    test_saturation();
    test_back_to_back();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/radix2_bf_pipe.md
# radix2_bf_pipe

Parametrised, fully pipelined radix-2 butterfly for the FFT datapath, the successor to the single-register butterfly. It supports both decimation-in-frequency (DIF) and decimation-in-time (DIT) per transaction, with per-transaction ×½ scaling. Results are saturated rather than wrapped, and any saturation sets a sticky overflow flag. It sits between the stage delay-line/commutator and the next stage. Flow control is valid/ready, replacing the bare stall input.

## Interface
- DW, 12: bit width of each real/imag component of the data samples.
- TW, 12: bit width of each twiddle component, signed Q1.(TW-1).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  1  0 = DIF, 1 = DIT.
- in_scale  in  1  1 = divide both results by 2.
- in_a  in  2*DW  upper input, packed {re, im}, re in MSBs.
- in_b  in  2*DW  lower input, packed {re, im}.
- in_w  in  2*TW  twiddle, packed {re, im}.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_up  out  2*DW  upper result, packed {re, im}.
- out_lo  out  2*DW  lower result, packed {re, im}.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- DIF (mode=0): up = a + b; lo = (a − b)·w.
- DIT (mode=1): t = b·w; up = a + t; lo = a − t.
- Complex multiply of x by w:
  - re = xr·wr − xi·wi
  - im = xr·wi + xi·wr
  - Products are computed at full width, summed at full width, then arithmetic-shifted right by TW−1.
- Adders run at full width; no intermediate wrap.
- Final step for each of the four output components:
  - if scale=1, arithmetic right shift by 1;
  - then saturate to the signed DW range [−2^(DW−1), 2^(DW−1)−1].
- Any saturation in a beat that leaves the output register sets ovf = 1.
- ovf stays 1 until ovf_clr is sampled high.
- If saturation and ovf_clr coincide in the same cycle, set wins.
- Twiddle −1.0 (MSB only) is legal and exact. +1.0 is not representable.

## Timing
- 3-stage pipeline, latency 3 cycles from an accepted input to out_valid.
- Stage contents:
  - S1 registers the operands plus the DIF add/sub.
  - S2 registers the four partial products.
  - S3 combines, scales, rounds, saturates and drives the output registers.
- Throughput is 1 beat/cycle when out_ready = 1.
- Stall rule: stall = out_valid & ~out_ready. During a stall every stage holds, and in_ready = ~stall.
- Beats are accepted on in_valid & in_ready. Beats are consumed on out_valid & out_ready.
- in_ready is combinational from out_ready. No other input-to-output combinational path exists.
- Outputs are registered and stable for as long as out_valid & ~out_ready holds.
- Valid bubbles propagate; bubbles never stall the pipe.
- Reset values: out_valid = 0, out_up = 0, out_lo = 0, ovf = 0, all stage valids = 0.
  - in_ready = 1 after reset, since out_valid = 0.
- Reset asserted mid-operation discards all in-flight beats. No output is produced for them.

## Configuration
- RADIX2_ROUND_EN defined: every right shift (the TW−1 product shift and the scale shift) rounds half-up. This is done by adding 2^(n−1) before shifting by n, at full width, before saturation.
- RADIX2_ROUND_EN undefined: every right shift truncates (floor). No rounding adders are built.

## Structure
- Shared package fft_pkg holds:
  - DW/TW defaults;
  - the MODE_DIF/MODE_DIT constants;
  - a saturate function;
  - a round-shift function whose body depends on RADIX2_ROUND_EN.
- One sub-module, cmplx_mult_pipe:
  - registered four-product multiply, with an enable input;
  - used once, selected on x = a−b (DIF) or x = b (DIT).
- The top level holds the valid/stall chain, the DIT add/sub, scaling/saturation, and ovf.

## Test plan
All scenarios use DW = 12, TW = 12.
1. DIF, scale=0, w = (0x800, 0), a = (100, 50), b = (20, 10) → 3 cycles later up = (120, 60), lo = (−80, −40), ovf = 0.
2. DIT, scale=0, w = (0, 0x800) (i.e. −j), a = (100, 0), b = (30, 40) → up = (140, −30), lo = (60, 30).
3. DIF, scale=1, a = (101, 0), b = (0, 0), w = (0x800, 0):
   - up.re = 51 with RADIX2_ROUND_EN defined;
   - up.re = 50 without it.
4. DIF, scale=0, a = b = (2047, 0) → up.re = 2047 (saturated), ovf = 1. ovf stays 1 across later clean beats until ovf_clr pulses, then reads 0.
5. Stream 6 back-to-back beats, with out_ready held low for 5 cycles starting at the first out_valid:
   - out_up/out_lo hold steady and in_ready = 0 throughout the stall;
   - all 6 results emerge in order, with none lost or duplicated.
6. Assert rst_n low with 3 beats in flight → outputs go to 0 and out_valid = 0 immediately. After release, no stale beat appears and the next input emerges with latency 3.
